// File: rtl/ryg_pkg.sv
// Shared types for the two-road traffic-light bus.
// Phase and error encodings, bus patterns, sequencing helper.
package ryg_pkg;

  typedef enum logic [1:0] {
    PH_AG = 2'd0,
    PH_AY = 2'd1,
    PH_BG = 2'd2,
    PH_BY = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    E_NONE    = 3'd0,
    E_PATTERN = 3'd1,
    E_ORDER   = 3'd2,
    E_SHORT   = 3'd3,
    E_LONG    = 3'd4
  } err_t;

  typedef enum logic {
    S_ACQ   = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  // Bus words {r,y,g}, bit1 = road A, bit0 = road B
  localparam logic [5:0] BUS_AG = 6'b01_00_10;
  localparam logic [5:0] BUS_AY = 6'b01_10_00;
  localparam logic [5:0] BUS_BG = 6'b10_00_01;
  localparam logic [5:0] BUS_BY = 6'b10_01_00;

  function automatic phase_t next_phase(phase_t p);
    return phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/ryg_decode.sv
// Bus decoder: r/y/g to {legal, phase}.
// Any pattern other than the four legal words is illegal.
module ryg_decode
  import ryg_pkg::*;
(
  input  logic [1:0] r,
  input  logic [1:0] y,
  input  logic [1:0] g,
  output logic       legal,
  output phase_t     ph
);

  logic [5:0] bus;
  assign bus = {r, y, g};

  // match the bus against the four legal words
  always_comb begin
    legal = 1'b1;
    ph    = PH_AG;
    unique case (1'b1)
      (bus == BUS_AG): ph = PH_AG;
      (bus == BUS_AY): ph = PH_AY;
      (bus == BUS_BG): ph = PH_BG;
      (bus == BUS_BY): ph = PH_BY;
      default:         legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ryg_monitor.sv
// Receive-side monitor for the traffic-light bus.
// Tracks phase order and dwell, flags pattern/timing errors.
module ryg_monitor
  import ryg_pkg::*;
#(
  parameter int GREEN_CYC  = 3,
  parameter int YELLOW_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] r,
  input  logic [1:0] y,
  input  logic [1:0] g,
  input  logic       clr_err,
  output logic [1:0] phase,
  output logic       locked,
  output logic       err_pulse,
  output logic       err_sticky,
  output logic [2:0] err_code,
  output logic [7:0] cycles
);

  logic             dec_ok;
  phase_t           dec_ph;

  state_t           state_q, state_d;
  logic             last_ok_q;
  phase_t           last_ph_q;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] lim;
  logic [7:0]       cycles_q, cycles_d;
  logic             pulse_d, pulse_q;
  logic             sticky_q, sticky_d;
  err_t             code_q, code_d;
  err_t             err;

  ryg_decode u_dec (
    .r     (r),
    .y     (y),
    .g     (g),
    .legal (dec_ok),
    .ph    (dec_ph)
  );

  assign lim = (phase_q == PH_AG || phase_q == PH_BG)
             ? CNT_W'(GREEN_CYC) : CNT_W'(YELLOW_CYC);

  // sequencing, dwell check and error capture
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dwell_d  = dwell_q;
    cycles_d = cycles_q;
    err      = E_NONE;
    unique case (state_q)
      S_ACQ: begin
        if (!dec_ok) begin
          err = E_PATTERN;
        end else if (last_ok_q &&
                     dec_ph == next_phase(last_ph_q)) begin
          state_d = S_TRACK;
          phase_d = dec_ph;
          dwell_d = CNT_W'(1);
        end
      end
      S_TRACK: begin
        if (!dec_ok) begin
          err = E_PATTERN;
        end else if (dec_ph == phase_q) begin
          if (dwell_q >= lim)
            err = E_LONG;
          else if (dwell_q != '1)
            dwell_d = dwell_q + 1'b1;
        end else if (dec_ph == next_phase(phase_q)) begin
          if (dwell_q < lim) begin
            err = E_SHORT;
          end else begin
            phase_d = dec_ph;
            dwell_d = CNT_W'(1);
            if (dec_ph == PH_AG)
              cycles_d = cycles_q + 8'd1;
          end
        end else begin
          err = E_ORDER;
        end
      end
    endcase
    if (err != E_NONE) begin
      state_d = S_ACQ;
      dwell_d = '0;
    end
    pulse_d  = (err != E_NONE);
    sticky_d = sticky_q;
    code_d   = code_q;
    if (err != E_NONE) begin
      sticky_d = 1'b1;
      if (!sticky_q || clr_err)
        code_d = err;
    end else if (clr_err) begin
      sticky_d = 1'b0;
      code_d   = E_NONE;
    end
  end

  // state registers; last pattern follows the bus every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ACQ;
      last_ok_q <= 1'b0;
      last_ph_q <= PH_AG;
      phase_q   <= PH_AG;
      dwell_q   <= '0;
      cycles_q  <= '0;
      pulse_q   <= 1'b0;
      sticky_q  <= 1'b0;
      code_q    <= E_NONE;
    end else begin
      state_q   <= state_d;
      last_ok_q <= dec_ok;
      last_ph_q <= dec_ph;
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      cycles_q  <= cycles_d;
      pulse_q   <= pulse_d;
      sticky_q  <= sticky_d;
      code_q    <= code_d;
    end
  end

  assign phase      = phase_q;
  assign locked     = (state_q == S_TRACK);
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign err_code   = code_q;
  assign cycles     = cycles_q;

endmodule
